// File: rtl/instr_fetch_unit_if.sv
// Bundles the program-memory bus, the execute redirect and the decode handshake
// seen by the fetch stage.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_instr;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_instr;
  logic [ADDR_WIDTH-1:0] id_pc;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc,
    input  imem_instr, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc,
    output imem_instr, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads 1-cycle-latency program memory and hands
// {instruction, PC} pairs to decode through a 2-entry buffer; flushes on redirect.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PART  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [31:0]           buf_instr [2];
  logic [ADDR_WIDTH-1:0] buf_pc [2];
  logic                  head;
  logic                  tail;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  assign pop  = (state != EMPTY) & bus.id_ready;
  assign push = inflight & ~bus.redirect_valid;
  assign tail = head ^ (state == PART);

  // An issued fetch reserves a buffer slot now, because its data cannot be stalled
  // at the memory and must be captured the very next cycle.
  assign occupancy = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = ~bus.redirect_valid & (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      state        <= EMPTY;
      head         <= 1'b0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_target;
      inflight <= 1'b0;
      state    <= EMPTY;
      head     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
      end
      if (push) begin
        buf_instr[tail] <= bus.imem_instr;
        buf_pc[tail]    <= inflight_pc;
      end
      if (pop) begin
        head <= ~head;
      end
      state <= state + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = (state != EMPTY);
  assign bus.id_instr  = buf_instr[head];
  assign bus.id_pc     = buf_pc[head];

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && state == FULL));

endmodule
